flog_arbiter: RTL and testbench

FLOG_ARBITER -- requirements
Module: flog_arbiter

---
 rtl/flog_pkg.sv | 20 ++
 rtl/flog_arbiter_rr_picker.sv | 42 ++++
 rtl/flog_arbiter.sv | 161 ++++++++++++++++
 tb/tb_flog_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flog_pkg.sv
// flog_pkg
// Shared definitions for the flog datapath and its requester arbiter.
// Holds the bfloat16 field widths, the arbiter's default operand width and
// result-wait budget, and the arbiter FSM state type.
// Optional feature macro used by flog_arbiter: FLOG_ARB_TIMEOUT_EN.
package flog_pkg;

  localparam int EXP_WIDTH        = 8;
  localparam int FRACT_WIDTH      = 7;
  localparam int FLOG_DW          = 1 + EXP_WIDTH + FRACT_WIDTH;
  localparam int FLOG_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } flog_state_e;

endpackage

// File: rtl/flog_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin winner selection: the first valid requester at
// or after the pointer, wrapping around the vector.
// Ports:
//   valid  in   N          request vector
//   ptr    in   clog2(N)   highest-priority index this cycle
//   grant  out  N          one-hot winner (all zero when nothing is valid)
//   idx    out  clog2(N)   binary index of the winner
//   any    out  1          at least one request is valid
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down to the pointer itself so that the
  // last hit, which is the one that sticks, is the closest to the pointer.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = IW'((int'(ptr) + off) % N);
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flog_arbiter.sv
// flog_arbiter
// Shares one flog datapath among NUM_REQ requesters, one operation at a
// time: grant (round-robin), issue a start pulse, wait for the result, then
// hold the response until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_i / req_data_i   per-requester operand (slice k = requester k)
//   req_ready_o                one-hot accept, only in IDLE
//   dp_valid_o / dp_data_o     start pulse and held operand to the datapath
//   dp_valid_i / dp_result_i   datapath result pulse (ignored outside WAIT)
//   rsp_valid_o/_id_o/_data_o/_err_o, rsp_ready_i   response handshake
//   busy_o                     high whenever not IDLE
// Macro FLOG_ARB_TIMEOUT_EN: when defined, WAIT gives up after TIMEOUT_CYC
// cycles and returns an error response with zero data.
module flog_arbiter
  import flog_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DW          = FLOG_DW,
  parameter int TIMEOUT_CYC = FLOG_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DW-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       dp_valid_o,
  output logic [DW-1:0]              dp_data_o,
  input  logic                       dp_valid_i,
  input  logic [DW-1:0]              dp_result_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [DW-1:0]              rsp_data_o,
  output logic                       rsp_err_o,
  input  logic                       rsp_ready_i,
  output logic                       busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  flog_state_e       state;
  flog_state_e       next_state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     op_id;
  logic [DW-1:0]     op_data;
  logic [DW-1:0]     rsp_data;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              timed_out;
  logic              grant_now;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_now = (state == IDLE) && pick_any;

`ifdef FLOG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tmo_cnt;
  logic          rsp_err;

  // Counts WAIT cycles; the last allowed WAIT cycle is TIMEOUT_CYC-1 so the
  // FSM spends exactly TIMEOUT_CYC cycles in WAIT before giving up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign timed_out = (state == WAIT) && !dp_valid_i &&
                     (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  // Error flag travels with the captured response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (state == WAIT) begin
      if (dp_valid_i) begin
        rsp_err <= 1'b0;
      end else if (timed_out) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (pick_any) next_state = ISSUE;
      ISSUE: next_state = WAIT;
      WAIT:  if (dp_valid_i || timed_out) next_state = RESP;
      RESP:  if (rsp_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand/owner capture at grant, pointer advance past the winner, and
  // result capture in WAIT. A timeout forces the response data to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      op_id    <= '0;
      op_data  <= '0;
      rsp_data <= '0;
    end else begin
      if (grant_now) begin
        op_id   <= pick_idx;
        op_data <= req_data_i[pick_idx*DW +: DW];
        rr_ptr  <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == WAIT) begin
        if (dp_valid_i) begin
          rsp_data <= dp_result_i;
        end else if (timed_out) begin
          rsp_data <= '0;
        end
      end
    end
  end

  // Outputs decoded from state; response fields read zero outside RESP.
  always_comb begin
    req_ready_o = (state == IDLE) ? pick_grant : '0;
    dp_valid_o  = (state == ISSUE);
    dp_data_o   = op_data;
    busy_o      = (state != IDLE);
    rsp_valid_o = (state == RESP);
    rsp_id_o    = (state == RESP) ? op_id : '0;
    rsp_data_o  = (state == RESP) ? rsp_data : '0;
`ifdef FLOG_ARB_TIMEOUT_EN
    rsp_err_o   = (state == RESP) && rsp_err;
`else
    rsp_err_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_flog_arbiter.sv
// tb_flog_arbiter
// Self-checking bench for flog_arbiter (NUM_REQ=4, DW=16, TIMEOUT_CYC=64).
// A reference model predicts grants from the round-robin rule and queues the
// expected datapath operands and responses; a negedge monitor compares the
// DUT against those queues. Stimulus is driven 1 time unit after posedge.
// Macro FLOG_ARB_TIMEOUT_EN enables the silent-datapath phase.
module tb_flog_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DW          = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int IW          = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  dp_start;
  logic [DW-1:0]         dp_data;
  logic                  dp_done;
  logic [DW-1:0]         dp_result;
  logic                  rsp_valid;
  logic [IW-1:0]         rsp_id;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_err;
  logic                  rsp_ready;
  logic                  busy;

  flog_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DW          (DW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .dp_valid_o  (dp_start),
    .dp_data_o   (dp_data),
    .dp_valid_i  (dp_done),
    .dp_result_i (dp_result),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  int checks   = 0;
  int failures = 0;

  // Stimulus controls written by the main sequence only.
  int req_mode       = 0;  // 0 hold/none, 1 random, 2 all continuously valid
  int rsp_mode       = 0;  // 0 always ready, 1 random, 2 never ready
  int dp_lat_fixed   = 2;  // 0 = random latency 2..5
  bit dp_silent      = 1'b0;
  bit dp_override    = 1'b0;
  int dp_force_req   = 0;
  int single_req     = 0;

  // Monitor/model state written by the negedge monitor only.
  rsp_t              rsp_q[$];
  logic [DW-1:0]     op_q[$];
  bit                model_idle = 1'b1;
  int                model_rr   = 0;
  logic [NUM_REQ-1:0] hs_mask   = '0;
  bit                dp_issue_flag = 1'b0;
  logic [DW-1:0]     dp_issue_op   = '0;
  int                cyc = 0;
  int                last_issue_cyc = 0;
  int                wait_cnt = 0;
  bit                stable_valid = 1'b0;
  logic [31:0]       stable_val = '0;
  int                dp_pulses = 0;
  int                rsp_hs_cnt = 0;
  int                rsp_seen_cnt = 0;
  int                dut_grant_cyc[$];
  int                dut_grant_id[$];

  function automatic logic [DW-1:0] dp_fn(input logic [DW-1:0] a);
    return {a[15:8] ^ 8'hA5, a[7:0] + 8'h3C};
  endfunction

  // Round-robin rule: first valid index at or after ptr, wrapping.
  function automatic int rr_winner(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (v[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor and reference model, evaluated where everything is stable.
  always @(negedge clk) begin
    int               w;
    logic [NUM_REQ-1:0] exp_ready;
    rsp_t             e;
    logic [31:0]      snap;
    cyc++;
    if (!rst_n) begin
      checkOutput("rst_ctrl", 32'({req_ready, dp_start, rsp_valid, rsp_id, rsp_err, busy}), 32'd0);
      checkOutput("rst_data", {dp_data, rsp_data}, 32'd0);
      model_idle    = 1'b1;
      model_rr      = 0;
      rsp_q.delete();
      op_q.delete();
      hs_mask       = '0;
      dp_issue_flag = 1'b0;
      stable_valid  = 1'b0;
      wait_cnt      = 0;
    end else begin
      w = model_idle ? rr_winner(req_valid, model_rr) : -1;
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("busy", 32'(busy), 32'(!model_idle));
      hs_mask = req_valid & req_ready;
      if (req_ready != '0) begin
        dut_grant_cyc.push_back(cyc);
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) dut_grant_id.push_back(k);
      end
      if (w >= 0) begin
        op_q.push_back(req_data[w*DW +: DW]);
        e.id   = IW'(w);
        e.err  = dp_silent;
        e.data = dp_silent ? '0 : (dp_override ? 16'h3F80 : dp_fn(req_data[w*DW +: DW]));
        rsp_q.push_back(e);
        model_rr   = (w + 1) % NUM_REQ;
        model_idle = 1'b0;
      end

      dp_issue_flag = dp_start;
      if (dp_start) begin
        dp_pulses++;
        last_issue_cyc = cyc;
        dp_issue_op    = dp_data;
        if (op_q.size() == 0) checkOutput("dp_spurious_issue", 32'(dp_start), 32'd0);
        else checkOutput("dp_operand", 32'(dp_data), 32'(op_q.pop_front()));
      end

      snap = 32'({rsp_id, rsp_data, rsp_err});
      if (rsp_valid) begin
        rsp_seen_cnt++;
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          if (stable_valid) checkOutput("rsp_stable", snap, stable_val);
          else if (rsp_q[0].err) checkOutput("tmo_latency", 32'(cyc - last_issue_cyc), 32'(TIMEOUT_CYC + 1));
          if (rsp_ready) begin
            e = rsp_q.pop_front();
            checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
            checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            rsp_hs_cnt++;
            model_idle   = 1'b1;
            stable_valid = 1'b0;
          end else begin
            stable_valid = 1'b1;
            stable_val   = snap;
          end
        end
      end else begin
        stable_valid = 1'b0;
      end

      if (!model_idle) begin
        wait_cnt++;
        if (wait_cnt > 400) begin
          checkOutput("rsp_watchdog_cycles", 32'(wait_cnt), 32'd400);
          model_idle = 1'b1;
          rsp_q.delete();
          op_q.delete();
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Requester, datapath and consumer agents, driven just after posedge.
  always @(posedge clk) begin
    int dp_cnt;
    logic [DW-1:0] dp_op;
    int dp_force_done;
    int single_done;
    #1;
    dp_done = 1'b0;
    if (dp_force_req != dp_force_done) begin
      dp_force_done = dp_force_req;
      dp_done   = 1'b1;
      dp_result = 16'h1234;
    end
    if (!rst_n) begin
      req_valid = '0;
      dp_cnt    = 0;
    end else begin
      if (dp_issue_flag) begin
        dp_cnt = ((dp_lat_fixed > 0) ? dp_lat_fixed : int'($urandom_range(5, 2))) - 1;
        dp_op  = dp_issue_op;
      end else if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0 && !dp_silent) begin
          dp_done   = 1'b1;
          dp_result = dp_override ? 16'h3F80 : dp_fn(dp_op);
        end
      end

      req_valid = req_valid & ~hs_mask;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_mode == 1) begin
          if (!req_valid[k]) begin
            if ($urandom_range(2, 0) == 0) begin
              req_valid[k] = 1'b1;
              req_data[k*DW +: DW] = DW'($urandom);
            end
          end else if ($urandom_range(15, 0) == 0) begin
            req_valid[k] = 1'b0;
          end
        end else if (req_mode == 2 && !req_valid[k]) begin
          req_valid[k] = 1'b1;
          req_data[k*DW +: DW] = DW'($urandom);
        end
      end
      if (single_req != single_done && !req_valid[2]) begin
        single_done  = single_req;
        req_valid[2] = 1'b1;
        req_data[2*DW +: DW] = 16'h4000;
      end
    end
    case (rsp_mode)
      1:       rsp_ready = 1'($urandom_range(1, 0));
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic applyStimulus(input int rm, input int rs, input int lat, input int ncyc);
    req_mode     = rm;
    rsp_mode     = rs;
    dp_lat_fixed = lat;
    waitCycles(ncyc);
  endtask

  task automatic doReset();
    req_mode = 0;
    waitCycles(1);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int start;
    int dp0;
    int hs0;
    int seen0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    dp_done   = 1'b0;
    dp_result = '0;
    rsp_ready = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;

    // All requesters continuously valid, immediate consumer, 2-cycle datapath.
    $display("[TB] phase: round-robin order and spacing");
    start = dut_grant_cyc.size();
    applyStimulus(2, 0, 2, 24);
    applyStimulus(0, 0, 2, 30);
    checkOutput("rr_grant_count_ok", 32'(dut_grant_cyc.size() >= start + 5), 32'd1);
    if (dut_grant_cyc.size() >= start + 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("rr_order", 32'(dut_grant_id[start + i]), 32'(exp_order[i]));
        if (i < 4) checkOutput("grant_spacing",
                               32'(dut_grant_cyc[start + i + 1] - dut_grant_cyc[start + i]), 32'd5);
      end
    end

    // Single request from requester 2, datapath returns 0x3F80.
    $display("[TB] phase: single request");
    doReset();
    dp_override = 1'b1;
    dp0 = dp_pulses;
    hs0 = rsp_hs_cnt;
    single_req++;
    applyStimulus(0, 0, 2, 15);
    checkOutput("single_dp_pulses", 32'(dp_pulses - dp0), 32'd1);
    checkOutput("single_responses", 32'(rsp_hs_cnt - hs0), 32'd1);
    dp_override = 1'b0;

    // Randomized traffic with random consumer stalls and datapath latency.
    $display("[TB] phase: random traffic");
    applyStimulus(1, 1, 0, 600);
    applyStimulus(0, 0, 0, 80);

    // Consumer stalls 15 cycles while other requesters wait.
    $display("[TB] phase: response backpressure");
    dp0 = dp_pulses;
    applyStimulus(2, 2, 2, 15);
    checkOutput("stall_dp_pulses", 32'(dp_pulses - dp0), 32'd1);
    applyStimulus(0, 0, 2, 40);

    // Spurious datapath result while idle.
    $display("[TB] phase: spurious result in idle");
    hs0   = rsp_hs_cnt;
    seen0 = rsp_seen_cnt;
    dp_force_req++;
    waitCycles(5);
    checkOutput("idle_spurious_rsp", 32'(rsp_seen_cnt - seen0), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Reset in WAIT, late result one cycle after release.
    $display("[TB] phase: reset mid-operation");
    dp0 = dp_pulses;
    single_req++;
    dp_lat_fixed = 6;
    for (int i = 0; i < 10; i++) begin
      if (dp_pulses != dp0) break;
      waitCycles(1);
    end
    checkOutput("rst_issue_seen", 32'(dp_pulses - dp0), 32'd1);
    waitCycles(2);
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    dp_force_req++;
    seen0 = rsp_seen_cnt;
    waitCycles(10);
    checkOutput("rst_no_response", 32'(rsp_seen_cnt - seen0), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

`ifdef FLOG_ARB_TIMEOUT_EN
    // Silent datapath: error response after TIMEOUT_CYC WAIT cycles.
    $display("[TB] phase: datapath timeout");
    dp_silent = 1'b1;
    hs0 = rsp_hs_cnt;
    single_req++;
    applyStimulus(0, 0, 2, TIMEOUT_CYC + 20);
    checkOutput("tmo_responses", 32'(rsp_hs_cnt - hs0), 32'd1);
    seen0 = rsp_seen_cnt;
    dp_force_req++;
    waitCycles(5);
    checkOutput("tmo_late_ignored", 32'(rsp_seen_cnt - seen0), 32'd0);
    dp_silent = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
